// File: rtl/mem_wb_pipe_if.sv
// Handshake and payload bundle between the MEM stage, the MEM->WB register and the WB stage.
// master = the stage environment (drives MEM inputs and WB ready), slave = the pipeline register.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wd;
  logic              in_wreg;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_hi;
  logic [DATA_W-1:0] in_lo;
  logic              in_whilo;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_wd;
  logic              out_wreg;
  logic [DATA_W-1:0] out_wdata;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;
  logic              out_whilo;

  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush,
    output in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo,
    input  in_ready,
    output out_ready,
    input  out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
    input  stall_cnt
  );

  modport slave (
    input  flush,
    input  in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo,
    output in_ready,
    input  out_ready,
    output out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
    output stall_cnt
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with valid/ready flow control, flush and a saturating stall counter.
// Define MEM_WB_SKID_EN for the three-state version with a skid entry and registered in_ready.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  mem_wb_pipe_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } payload_t;

  payload_t         in_pl;
  payload_t         main_q;
  logic             out_valid;
  logic             in_ready;
  logic             accept;
  logic             take;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  assign in_pl.wd    = bus.in_wd;
  assign in_pl.wreg  = bus.in_wreg;
  assign in_pl.wdata = bus.in_wdata;
  assign in_pl.hi    = bus.in_hi;
  assign in_pl.lo    = bus.in_lo;
  assign in_pl.whilo = bus.in_whilo;

  assign accept = bus.in_valid && in_ready;
  assign take   = out_valid && bus.out_ready;

`ifdef MEM_WB_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t   state_q;
  payload_t skid_q;
  logic     out_valid_q;
  logic     in_ready_q;

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

  // Write enables in main_q are cleared whenever the stage empties so the
  // outputs come straight from flops and still obey the bubble rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus.flush) begin
      state_q      <= ST_EMPTY;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q.wreg  <= 1'b0;
      main_q.whilo <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= in_pl;
            out_valid_q <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && take) begin
            main_q <= in_pl;
          end else if (accept) begin
            skid_q     <= in_pl;
            in_ready_q <= 1'b0;
            state_q    <= ST_SKID;
          end else if (take) begin
            out_valid_q  <= 1'b0;
            main_q.wreg  <= 1'b0;
            main_q.whilo <= 1'b0;
            state_q      <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (take) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_FULL;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`else

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state_q;

  assign out_valid = (state_q == ST_FULL);
  // Single entry: room exists if empty or the held entry leaves this cycle.
  assign in_ready  = !out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else if (bus.flush) begin
      state_q      <= ST_EMPTY;
      main_q.wreg  <= 1'b0;
      main_q.whilo <= 1'b0;
    end else if (accept) begin
      main_q  <= in_pl;
      state_q <= ST_FULL;
    end else if (take) begin
      state_q      <= ST_EMPTY;
      main_q.wreg  <= 1'b0;
      main_q.whilo <= 1'b0;
    end
  end

`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_wd    = main_q.wd;
  assign bus.out_wreg  = main_q.wreg;
  assign bus.out_wdata = main_q.wdata;
  assign bus.out_hi    = main_q.hi;
  assign bus.out_lo    = main_q.lo;
  assign bus.out_whilo = main_q.whilo;
  assign bus.stall_cnt = stall_cnt_q;

`ifndef SYNTHESIS
  a_bubble: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (!bus.out_wreg && !bus.out_whilo));

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !bus.out_ready && !bus.flush) |=> (out_valid && $stable(main_q)));
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: reset, streaming, back-pressure, flush, reset mid-run, saturation.
// Expectations follow MEM_WB_SKID_EN the same way the design does.
module tb_mem_wb_pipe;

  logic clk;
  logic rst;

  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_sat ();

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] wd, input logic [31:0] wdata, input logic [31:0] hi,
                      input logic wreg, input logic whilo);
    bus.in_valid = 1'b1;
    bus.in_wd    = wd;
    bus.in_wdata = wdata;
    bus.in_hi    = hi;
    bus.in_lo    = ~wdata;
    bus.in_wreg  = wreg;
    bus.in_whilo = whilo;
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_wd        = '0;
    bus.in_wreg      = 1'b0;
    bus.in_wdata     = '0;
    bus.in_hi        = '0;
    bus.in_lo        = '0;
    bus.in_whilo     = 1'b0;
    bus.out_ready    = 1'b0;
    bus_sat.flush    = 1'b0;
    bus_sat.in_valid = 1'b0;
    bus_sat.in_wd    = '0;
    bus_sat.in_wreg  = 1'b0;
    bus_sat.in_wdata = '0;
    bus_sat.in_hi    = '0;
    bus_sat.in_lo    = '0;
    bus_sat.in_whilo = 1'b0;
    bus_sat.out_ready = 1'b0;

    // reset then idle
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_wreg",  64'(bus.out_wreg),  64'd0);
    check_val("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_val("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check_val("rst_out_wdata", 64'(bus.out_wdata), 64'd0);

    // single entry, one-cycle latency
    bus.out_ready = 1'b1;
    send(5'd3, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    tick();
    check_val("stream_valid", 64'(bus.out_valid), 64'd1);
    check_val("stream_wd",    64'(bus.out_wd),    64'd3);
    check_val("stream_wdata", 64'(bus.out_wdata), 64'hDEADBEEF);
    check_val("stream_wreg",  64'(bus.out_wreg),  64'd1);
    check_val("stream_lo",    64'(bus.out_lo),    64'h21524110);

    // back-to-back 1..8, no gaps
    for (int i = 1; i <= 8; i++) begin
      send(5'(i), 32'h100 + 32'(i), 32'h0, 1'b1, 1'b0);
      check_val($sformatf("b2b_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      tick();
      check_val($sformatf("b2b_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      check_val($sformatf("b2b_wdata_%0d", i), 64'(bus.out_wdata), 64'h100 + 64'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    check_val("drain_valid", 64'(bus.out_valid), 64'd0);
    check_val("drain_wreg",  64'(bus.out_wreg),  64'd0);
    check_val("drain_hold",  64'(bus.out_wdata), 64'h108);

    // back-pressure: A, B, C with out_ready low
    bus.out_ready = 1'b0;
    send(5'd10, 32'hAAAA_0001, 32'h0, 1'b1, 1'b0);
    tick();
    check_val("bp_a_valid", 64'(bus.out_valid), 64'd1);
    check_val("bp_a_wdata", 64'(bus.out_wdata), 64'hAAAA_0001);
`ifdef MEM_WB_SKID_EN
    check_val("bp_a_in_ready", 64'(bus.in_ready), 64'd1);
    send(5'd11, 32'hBBBB_0002, 32'h0, 1'b1, 1'b0);
    tick();
    check_val("bp_b_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("bp_b_hold",     64'(bus.out_wdata), 64'hAAAA_0001);
    send(5'd12, 32'hCCCC_0003, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    check_val("bp_c_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("bp_c_hold",     64'(bus.out_wdata), 64'hAAAA_0001);
    check_val("bp_stall_cnt",  64'(bus.stall_cnt), 64'd3);
    bus.out_ready = 1'b1;
    tick();
    check_val("bp_out_b_wdata", 64'(bus.out_wdata), 64'hBBBB_0002);
    check_val("bp_out_b_wd",    64'(bus.out_wd),    64'd11);
    check_val("bp_out_b_ready", 64'(bus.in_ready),  64'd1);
    tick();
    check_val("bp_out_c_wdata", 64'(bus.out_wdata), 64'hCCCC_0003);
`else
    check_val("bp_a_in_ready", 64'(bus.in_ready), 64'd0);
    send(5'd11, 32'hBBBB_0002, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check_val("bp_b_hold",    64'(bus.out_wdata), 64'hAAAA_0001);
    check_val("bp_stall_cnt", 64'(bus.stall_cnt), 64'd3);
    bus.out_ready = 1'b1;
    #1;
    check_val("comb_ready_hi", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
    #1;
    check_val("comb_ready_lo", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    check_val("bp_out_b_wdata", 64'(bus.out_wdata), 64'hBBBB_0002);
    check_val("bp_out_b_wd",    64'(bus.out_wd),    64'd11);
    send(5'd12, 32'hCCCC_0003, 32'h0, 1'b1, 1'b0);
    tick();
    check_val("bp_out_c_wdata", 64'(bus.out_wdata), 64'hCCCC_0003);
`endif
    bus.in_valid = 1'b0;
    tick();
    check_val("bp_empty_valid", 64'(bus.out_valid), 64'd0);
    check_val("bp_empty_stall", 64'(bus.stall_cnt), 64'd3);

    // flush wins over an accept in the same cycle
    send(5'd4, 32'h4444_4444, 32'h1, 1'b0, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_val("flush_in_valid", 64'(bus.out_valid), 64'd0);
    check_val("flush_in_whilo", 64'(bus.out_whilo), 64'd0);
    tick();
    check_val("flush_dropped_valid", 64'(bus.out_valid), 64'd0);
    check_val("flush_dropped_hi",    64'(bus.out_hi),    64'd0);

    // flush of a held entry; counter survives flush
    bus.out_ready = 1'b0;
    send(5'd7, 32'hD0D0_D0D0, 32'h55, 1'b1, 1'b1);
    tick();
    check_val("d_valid", 64'(bus.out_valid), 64'd1);
    check_val("d_whilo", 64'(bus.out_whilo), 64'd1);
    check_val("d_hi",    64'(bus.out_hi),    64'h55);
    send(5'd8, 32'hE0E0_E0E0, 32'h66, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_val("fl_full_valid", 64'(bus.out_valid), 64'd0);
    check_val("fl_full_wreg",  64'(bus.out_wreg),  64'd0);
    check_val("fl_full_whilo", 64'(bus.out_whilo), 64'd0);
    check_val("fl_full_hold",  64'(bus.out_wdata), 64'hD0D0_D0D0);
    check_val("fl_full_stall", 64'(bus.stall_cnt), 64'd4);
    bus.out_ready = 1'b1;
    tick();
    check_val("fl_e_dropped", 64'(bus.out_valid), 64'd0);

    // reset mid-operation discards held entries
    bus.out_ready = 1'b0;
    send(5'd9, 32'hF0F0_0001, 32'h0, 1'b1, 1'b0);
    tick();
    send(5'd9, 32'hF0F0_0002, 32'h0, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    rst          = 1'b1;
    tick();
    rst       = 1'b0;
    bus.flush = 1'b0;
    check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_wdata", 64'(bus.out_wdata), 64'd0);
    check_val("mid_rst_stall", 64'(bus.stall_cnt), 64'd0);
    check_val("mid_rst_ready", 64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    tick();
    check_val("mid_rst_no_skid", 64'(bus.out_valid), 64'd0);

    // saturation with a 4-bit counter
    bus_sat.in_valid = 1'b1;
    bus_sat.in_wd    = 5'd1;
    bus_sat.in_wreg  = 1'b1;
    bus_sat.in_wdata = 32'h1234_5678;
    tick();
    bus_sat.in_valid = 1'b0;
    check_val("sat_loaded", 64'(bus_sat.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    check_val("sat_cnt_10", 64'(bus_sat.stall_cnt), 64'd10);
    for (int i = 0; i < 10; i++) tick();
    check_val("sat_cnt_20", 64'(bus_sat.stall_cnt), 64'd15);
    check_val("sat_hold",   64'(bus_sat.out_wdata), 64'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline register with valid/ready flow control, flush, and an optional two-entry skid buffer. It carries the destination register write and the HI/LO write from the memory-access stage to the write-back stage. It holds data under back-pressure and inserts bubbles on flush. It replaces the fixed-width, always-advancing MEM/WB latch in pipelines that need stall and flush support.

## Interface
Parameters:
- DATA_W, 32, width of wdata/hi/lo
- ADDR_W, 5, width of destination register address
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  MEM stage presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_wd  in  ADDR_W  destination register address
- in_wreg  in  1  GPR write enable
- in_wdata  in  DATA_W  GPR write data
- in_hi, in_lo  in  DATA_W  HI/LO write data
- in_whilo  in  1  HI/LO write enable
- out_valid  out  1  WB stage holds a valid instruction
- out_ready  in  1  WB consumes the entry this cycle
- out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo  out  as inputs  registered payload
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Accept: `in_valid && in_ready`. Take: `out_valid && out_ready`.
- With skid, the block is a three-state FSM:
  - EMPTY: on accept, main ← in, go to FULL.
  - FULL: accept and take → main ← in, stay in FULL. Accept with no take → skid ← in, go to SKID. Take with no accept → EMPTY.
  - SKID: in_ready = 0. On take, main ← skid, go to FULL.
- in_ready = (state != SKID). It is registered, with no combinational path from out_ready.
- Bubble rule: whenever out_valid = 0, out_wreg = 0 and out_whilo = 0. The other payload outputs hold their last value.
- flush: next state is EMPTY, out_valid = 0, out_wreg = out_whilo = 0. flush overrides any accept or take in the same cycle; the input presented that cycle is dropped.
- stall_cnt increments every cycle in which out_valid && !out_ready. It saturates at 2^CNT_W−1 and is cleared only by rst.
- Payload bits pass through unmodified at full width. No arithmetic is applied to the payload.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, with out_valid = 1 in cycle N+1.
- Throughput: one entry per cycle while out_ready = 1.
- Reset values: out_valid = 0, in_ready = 1, out_wd = 0, out_wreg = 0, out_wdata = out_hi = out_lo = 0, out_whilo = 0, stall_cnt = 0, state = EMPTY, skid cleared.
- rst takes priority over flush. Reset mid-operation discards both the main and skid entries.
- Holding out_ready = 0 keeps out_* stable: payload is bit-exact, with no glitches between edges.

## Configuration
- MEM_WB_SKID_EN defined: three-state FSM with skid entry and registered in_ready, as described above.
- MEM_WB_SKID_EN undefined: two states only (EMPTY/FULL) and no skid register.
  - in_ready = !out_valid || out_ready, combinational.
  - All other rules are unchanged: flush, bubble gating, stall_cnt, and reset values.

## Test plan
- Reset then idle: after rst is held for 2 cycles, out_valid = 0, out_wreg = 0, in_ready = 1, stall_cnt = 0.
- Streaming: present wd = 5'd3, wdata = 32'hDEADBEEF, wreg = 1 with out_ready = 1 → the same values appear on out_* the next cycle with out_valid = 1. Back-to-back entries 1..8 emerge in order with no gaps.
- Back-pressure (skid): send A, B, C with out_ready = 0.
  - A lands in main and B in skid; in_ready drops to 0 and C is held at the input.
  - After out_ready = 1, the order out is A, B, C.
  - stall_cnt equals the number of stalled cycles.
- Flush priority: flush = 1 in the same cycle as in_valid = 1 carrying whilo = 1, hi = 32'h1 → next cycle out_valid = 0 and out_whilo = 0, and the entry is never output.
- Saturation: with CNT_W = 4, hold out_valid with out_ready = 0 for 20 cycles → stall_cnt = 15.
- Macro off: with out_valid = 1, toggle out_ready → in_ready follows out_ready in the same cycle, and the FSM never holds more than one entry.
